// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   opcode/funct3/funct7_5 instruction fields from IR, valid the cycle after ir_write
//   mem_ready             completes the pending imem_req / MemRead / MemWrite
//   imem_req, ir_write    instruction fetch request and IR load (ir_write = fetch acked)
//   pc_write, branch      PC commit and branch enable
//   MemRead, MemWrite     data memory request, held until mem_ready
//   MemToReg, ALUSrc      writeback mux and ALU operand-B mux selects
//   RegWrite, ALU_op      register file write enable and ALU operation
//   trap, trap_cause      sticky trap flag and cause (1 illegal, 2 fetch timeout, 3 mem timeout)
//   instret               retired-instruction counter, wraps
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             mem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [3:0]       ALU_op,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4,
        C_JAL    = 3'd5,
        C_JALR   = 3'd6,
        C_ILL    = 3'd7
    } cls_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Last wait cycle allowed without mem_ready; a ready on this cycle still completes.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        case (op)
            7'b0110011: c = C_R;
            7'b0010011: c = C_I;
            7'b0000011: c = C_LOAD;
            7'b0100011: c = C_STORE;
            7'b1100011: c = C_BRANCH;
            7'b1101111: c = C_JAL;
            7'b1100111: c = C_JALR;
            default:    c = C_ILL;
        endcase
        return c;
    endfunction

    // funct7_5 only means SUB for register-register ops; for OP-IMM it is an immediate bit,
    // except on the shift-right encoding where it selects arithmetic shift.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] a;
        case (f3)
            3'b000:  a = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    state_t           state, state_next;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic             funct7_q;
    logic [7:0]       wait_cnt;
    logic [1:0]       trap_cause_q;
    logic [1:0]       cause_next;
    logic [CNT_W-1:0] instret_q;
    cls_t             cls_q;

    assign cls_q      = classify(opcode_q);
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_FETCH;
            opcode_q     <= 7'd0;
            funct3_q     <= 3'd0;
            funct7_q     <= 1'b0;
            wait_cnt     <= 8'd0;
            trap_cause_q <= 2'd0;
            instret_q    <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                opcode_q <= opcode;
                funct3_q <= funct3;
                funct7_q <= funct7_5;
            end
            // Counts consecutive un-acked cycles; any state change or ack restarts it.
            if ((state == S_FETCH || state == S_MEM) && state_next == state && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (state != S_TRAP && state_next == S_TRAP) begin
                trap_cause_q <= cause_next;
            end
            if (pc_write) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        cause_next = 2'd0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemToReg   = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        ALU_op     = ALU_ADD;
        trap       = 1'b0;
        // Every strobe is forced low while reset is held, including mid-access.
        if (reset) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        state_next = S_DECODE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state_next = S_TRAP;
                        cause_next = 2'd2;
                    end
                end
                S_DECODE: begin
                    if (classify(opcode) == C_ILL) begin
                        state_next = S_TRAP;
                        cause_next = 2'd1;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_R: begin
                            ALU_op     = alu_decode(funct3_q, funct7_q, 1'b1);
                            state_next = S_WB;
                        end
                        C_I: begin
                            ALUSrc     = 1'b1;
                            ALU_op     = alu_decode(funct3_q, funct7_q, 1'b0);
                            state_next = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            ALUSrc     = 1'b1;
                            state_next = S_MEM;
                        end
                        C_BRANCH: begin
                            branch     = 1'b1;
                            ALU_op     = ALU_SUB;
                            pc_write   = 1'b1;
                            state_next = S_FETCH;
                        end
                        C_JAL, C_JALR: begin
                            ALUSrc     = 1'b1;
                            RegWrite   = 1'b1;
                            pc_write   = 1'b1;
                            state_next = S_FETCH;
                        end
                        default: begin
                            state_next = S_TRAP;
                            cause_next = 2'd1;
                        end
                    endcase
                end
                S_MEM: begin
                    ALUSrc = 1'b1;
                    if (cls_q == C_LOAD) begin
                        MemRead = 1'b1;
                    end else begin
                        MemWrite = 1'b1;
                    end
                    if (mem_ready) begin
                        if (cls_q == C_LOAD) begin
                            state_next = S_WB;
                        end else begin
                            pc_write   = 1'b1;
                            state_next = S_FETCH;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state_next = S_TRAP;
                        cause_next = 2'd3;
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    MemToReg   = (cls_q == C_LOAD);
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int CL_R  = 0;
    localparam int CL_I  = 1;
    localparam int CL_LD = 2;
    localparam int CL_ST = 3;
    localparam int CL_BR = 4;
    localparam int CL_J  = 5;
    localparam int CL_IL = -1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic          funct7_5 = 1'b0;
    logic          mem_ready = 1'b0;
    logic          imem_req, ir_write, pc_write, branch, MemRead, MemWrite;
    logic          MemToReg, ALUSrc, RegWrite, trap;
    logic [3:0]    ALU_op;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ir = 0;

    logic [12:0] obs_vec;
    assign obs_vec = {imem_req, ir_write, pc_write, branch, MemRead, MemWrite,
                      MemToReg, ALUSrc, RegWrite, ALU_op};

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .mem_ready(mem_ready), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALU_op(ALU_op), .trap(trap),
        .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] vec(input bit im, input bit irw, input bit pcw, input bit br,
                                        input bit mr, input bit mw, input bit m2r, input bit as,
                                        input bit rw, input logic [3:0] op);
        return {im, irw, pcw, br, mr, mw, m2r, as, rw, op};
    endfunction

    function automatic int iclass(input logic [6:0] opc);
        case (opc)
            7'h33:   return CL_R;
            7'h13:   return CL_I;
            7'h03:   return CL_LD;
            7'h23:   return CL_ST;
            7'h63:   return CL_BR;
            7'h6F:   return CL_J;
            7'h67:   return CL_J;
            default: return CL_IL;
        endcase
    endfunction

    // ALU operation table: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9
    function automatic logic [3:0] ref_alu(input int cls, input logic [2:0] f3, input logic f7);
        if (cls == CL_BR) return 4'd1;
        if (cls != CL_R && cls != CL_I) return 4'd0;
        case (f3)
            3'd0:    return (cls == CL_R && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd8;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic [12:0] ev, input logic et,
                        input logic [1:0] ec, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        check({tag, "_strobes"}, 32'(obs_vec), 32'(ev));
        check({tag, "_trap"}, 32'(trap), 32'(et));
        check({tag, "_cause"}, 32'(trap_cause), 32'(ec));
        check({tag, "_instret"}, 32'(instret), 32'(model_ir));
        if (ev[10]) model_ir = (model_ir + 1) % (1 << CW);
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input logic rdy, input logic [12:0] ev, input string tag);
        step(rdy, ev, 1'b0, 2'd0, tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_strobes", 32'(obs_vec), 32'd0);
        check("reset_trap", 32'(trap), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_ready = 1'b0;
        model_ir = 0;
    endtask

    task automatic fetch_decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input int fw);
        opcode = opc;
        funct3 = f3;
        funct7_5 = f7;
        for (int i = 0; i < fw; i++) step_n(1'b0, vec(1,0,0,0,0,0,0,0,0,4'd0), "fetch_wait");
        step_n(1'b1, vec(1,1,0,0,0,0,0,0,0,4'd0), "fetch_ack");
        step_n(rnd(), 13'd0, "decode");
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input int fw, input int mw);
        int         cls;
        logic [3:0] op;
        cls = iclass(opc);
        op  = ref_alu(cls, f3, f7);
        fetch_decode(opc, f3, f7, fw);
        case (cls)
            CL_R: begin
                step_n(rnd(), vec(0,0,0,0,0,0,0,0,0,op), "exec_r");
                step_n(rnd(), vec(0,0,1,0,0,0,0,0,1,4'd0), "wb_r");
            end
            CL_I: begin
                step_n(rnd(), vec(0,0,0,0,0,0,0,1,0,op), "exec_i");
                step_n(rnd(), vec(0,0,1,0,0,0,0,0,1,4'd0), "wb_i");
            end
            CL_LD: begin
                step_n(rnd(), vec(0,0,0,0,0,0,0,1,0,4'd0), "exec_ld");
                for (int i = 0; i < mw; i++) step_n(1'b0, vec(0,0,0,0,1,0,0,1,0,4'd0), "mem_ld_wait");
                step_n(1'b1, vec(0,0,0,0,1,0,0,1,0,4'd0), "mem_ld_ack");
                step_n(rnd(), vec(0,0,1,0,0,0,1,0,1,4'd0), "wb_ld");
            end
            CL_ST: begin
                step_n(rnd(), vec(0,0,0,0,0,0,0,1,0,4'd0), "exec_st");
                for (int i = 0; i < mw; i++) step_n(1'b0, vec(0,0,0,0,0,1,0,1,0,4'd0), "mem_st_wait");
                step_n(1'b1, vec(0,0,1,0,0,1,0,1,0,4'd0), "mem_st_ack");
            end
            CL_BR: step_n(rnd(), vec(0,0,1,1,0,0,0,0,0,4'd1), "exec_br");
            default: step_n(rnd(), vec(0,0,1,0,0,0,0,1,1,4'd0), "exec_jump");
        endcase
    endtask

    initial begin
        logic [6:0] legal [7];
        legal[0] = 7'h33; legal[1] = 7'h13; legal[2] = 7'h03; legal[3] = 7'h23;
        legal[4] = 7'h63; legal[5] = 7'h6F; legal[6] = 7'h67;

        do_reset();
        run_instr(7'h33, 3'd0, 1'b0, 0, 0);     // ADD x3,x1,x2
        run_instr(7'h03, 3'd2, 1'b0, 0, 3);     // LW, ready 3 cycles late
        run_instr(7'h33, 3'd0, 1'b1, 0, 0);     // SUB
        run_instr(7'h33, 3'd5, 1'b1, 0, 0);     // SRA
        run_instr(7'h13, 3'd5, 1'b1, 0, 0);     // SRAI
        run_instr(7'h13, 3'd0, 1'b1, 0, 0);     // ADDI with imm bit 10 set
        run_instr(7'h33, 3'd3, 1'b0, 0, 0);     // SLTU
        run_instr(7'h63, 3'd0, 1'b0, 0, 0);     // BEQ
        run_instr(7'h6F, 3'd0, 1'b0, 1, 0);     // JAL
        run_instr(7'h67, 3'd0, 1'b0, 0, 0);     // JALR
        run_instr(7'h23, 3'd2, 1'b0, 0, 2);     // SW
        run_instr(7'h33, 3'd7, 1'b0, TO - 1, 0); // fetch ready on the last allowed cycle
        run_instr(7'h23, 3'd2, 1'b0, 0, TO - 1); // store ready on the last allowed cycle

        for (int n = 0; n < 40; n++) begin
            run_instr(legal[$urandom_range(0, 6)], 3'($urandom_range(0, 7)),
                      rnd(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end

        // Reset in the middle of a store access.
        fetch_decode(7'h23, 3'd2, 1'b0, 0);
        step_n(1'b0, vec(0,0,0,0,0,0,0,1,0,4'd0), "exec_st_rst");
        step_n(1'b0, vec(0,0,0,0,0,1,0,1,0,4'd0), "mem_st_rst");
        do_reset();
        step_n(1'b0, vec(1,0,0,0,0,0,0,0,0,4'd0), "post_reset_fetch");
        run_instr(7'h33, 3'd6, 1'b0, 0, 0);

        // Illegal opcode: sticky trap, mem_ready ignored.
        fetch_decode(7'h7F, 3'd0, 1'b0, 0);
        for (int i = 0; i < 20; i++) step(1'(i % 2), 13'd0, 1'b1, 2'd1, "trap_illegal");
        do_reset();

        // Fetch timeout.
        for (int i = 0; i < TO; i++) step_n(1'b0, vec(1,0,0,0,0,0,0,0,0,4'd0), "fetch_to_wait");
        for (int i = 0; i < 3; i++) step(rnd(), 13'd0, 1'b1, 2'd2, "trap_fetch_to");
        do_reset();

        // Memory timeout on a load.
        fetch_decode(7'h03, 3'd2, 1'b0, 0);
        step_n(1'b0, vec(0,0,0,0,0,0,0,1,0,4'd0), "exec_ld_to");
        for (int i = 0; i < TO; i++) step_n(1'b0, vec(0,0,0,0,1,0,0,1,0,4'd0), "mem_to_wait");
        for (int i = 0; i < 3; i++) step(rnd(), 13'd0, 1'b1, 2'd3, "trap_mem_to");
        do_reset();

        run_instr(7'h33, 3'd0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
